// File: rtl/parking_pkg.sv
// Shared types and constants for the car park gate controller.
package parking_pkg;

  // Gate controller states
  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    WAIT_PASSWORD = 3'd1,
    WRONG_PASS    = 3'd2,
    RIGHT_PASS    = 3'd3,
    STOP          = 3'd4
  } state_t;

  // Active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_N     = 7'b0101011;
  localparam logic [6:0] SEG_G     = 7'b0000010;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [6:0] SEG_P     = 7'b0001100;

  // True for states whose indicator LED blinks
  function automatic logic is_blink_state(input state_t s);
    logic v;
    case (s)
      WRONG_PASS, RIGHT_PASS, STOP: v = 1'b1;
      default:                      v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/parking_display.sv
// Registered state-to-HEX decoder for the two gate status digits.
module parking_display
  import parking_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_state,
  output logic [6:0] o_hex_1,
  output logic [6:0] o_hex_2
);

  logic [6:0] w_hex_1;
  logic [6:0] w_hex_2;
  logic [6:0] r_hex_1;
  logic [6:0] r_hex_2;

  // Decode the current state into the two-letter message
  always_comb begin
    w_hex_1 = SEG_BLANK;
    w_hex_2 = SEG_BLANK;
    case (state_t'(i_state))
      IDLE: begin
        w_hex_1 = SEG_BLANK;
        w_hex_2 = SEG_BLANK;
      end
      WAIT_PASSWORD: begin
        w_hex_1 = SEG_E;
        w_hex_2 = SEG_N;
      end
      WRONG_PASS: begin
        w_hex_1 = SEG_E;
        w_hex_2 = SEG_E;
      end
      RIGHT_PASS: begin
        w_hex_1 = SEG_G;
        w_hex_2 = SEG_O;
      end
      STOP: begin
        w_hex_1 = SEG_S;
        w_hex_2 = SEG_P;
      end
      default: begin
        w_hex_1 = SEG_BLANK;
        w_hex_2 = SEG_BLANK;
      end
    endcase
  end

  // Register the digits so the display is glitch-free; reset blanks them
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hex_1 <= SEG_BLANK;
      r_hex_2 <= SEG_BLANK;
    end else begin
      r_hex_1 <= w_hex_1;
      r_hex_2 <= w_hex_2;
    end
  end

  assign o_hex_1 = r_hex_1;
  assign o_hex_2 = r_hex_2;

endmodule

// File: rtl/parking_system.sv
// Car park entrance gate controller: FSM, password wait counter and LEDs.
// Optional feature macro: BLINK_EN (LEDs blink in WRONG_PASS/RIGHT_PASS/STOP;
// when undefined those LEDs are held steady at 1).
// Note: reset_n is active-high despite its name.
module parking_system
  import parking_pkg::*;
#(
  parameter int         WAIT_CYCLES = 3,
  parameter logic [1:0] PASS1       = 2'b01,
  parameter logic [1:0] PASS2       = 2'b10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sensor_entrance,
  input  logic       sensor_exit,
  input  logic [1:0] password_1,
  input  logic [1:0] password_2,
  output logic       GREEN_LED,
  output logic       RED_LED,
  output logic [6:0] HEX_1,
  output logic [6:0] HEX_2
);

  localparam int             CNT_W   = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_pw_ok;
  logic             w_blink_on;
  logic             w_green;
  logic             w_red;
  logic             r_green;
  logic             r_red;

  assign w_pw_ok = (password_1 == PASS1) && (password_2 == PASS2);

  // Next-state logic for the gate controller
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (sensor_entrance) w_next = WAIT_PASSWORD;
        else                 w_next = IDLE;
      end
      WAIT_PASSWORD: begin
        if (r_cnt == CNT_MAX) begin
          if (w_pw_ok) w_next = RIGHT_PASS;
          else         w_next = WRONG_PASS;
        end else begin
          w_next = WAIT_PASSWORD;
        end
      end
      WRONG_PASS: begin
        if (w_pw_ok) w_next = RIGHT_PASS;
        else         w_next = WRONG_PASS;
      end
      RIGHT_PASS: begin
        // entrance and exit together means a second car is tailgating
        if (sensor_entrance && sensor_exit) w_next = STOP;
        else if (sensor_exit)               w_next = IDLE;
        else                                w_next = RIGHT_PASS;
      end
      STOP: begin
        if (w_pw_ok) w_next = RIGHT_PASS;
        else         w_next = STOP;
      end
      default: w_next = IDLE;
    endcase
  end

  // Wait counter: counts only in WAIT_PASSWORD, saturating at CNT_MAX
  always_comb begin
    w_cnt_next = CNT_ZERO;
    if (r_state == WAIT_PASSWORD) begin
      if (r_cnt == CNT_MAX) w_cnt_next = r_cnt;
      else                  w_cnt_next = r_cnt + CNT_ONE;
    end else begin
      w_cnt_next = CNT_ZERO;
    end
  end

  // State and counter registers
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_state <= IDLE;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

`ifdef BLINK_EN
  logic r_blink;

  // Blink phase: toggles while in a blinking state, cleared otherwise
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_blink <= 1'b0;
    end else if (is_blink_state(r_state)) begin
      r_blink <= ~r_blink;
    end else begin
      r_blink <= 1'b0;
    end
  end

  // The LED follows the post-toggle phase so the first blinking cycle is lit
  assign w_blink_on = ~r_blink;
`else
  assign w_blink_on = 1'b1;
`endif

  // LED pattern per state
  always_comb begin
    w_green = 1'b0;
    w_red   = 1'b0;
    case (r_state)
      IDLE: begin
        w_green = 1'b0;
        w_red   = 1'b0;
      end
      WAIT_PASSWORD: begin
        w_green = 1'b0;
        w_red   = 1'b1;
      end
      WRONG_PASS: begin
        w_green = 1'b0;
        w_red   = w_blink_on;
      end
      RIGHT_PASS: begin
        w_green = w_blink_on;
        w_red   = 1'b0;
      end
      STOP: begin
        w_green = 1'b0;
        w_red   = w_blink_on;
      end
      default: begin
        w_green = 1'b0;
        w_red   = 1'b0;
      end
    endcase
  end

  // Registered LED outputs
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_green <= 1'b0;
      r_red   <= 1'b0;
    end else begin
      r_green <= w_green;
      r_red   <= w_red;
    end
  end

  assign GREEN_LED = r_green;
  assign RED_LED   = r_red;

  parking_display u_display (
    .i_clk   (clk),
    .i_rst   (reset_n),
    .i_state (r_state),
    .o_hex_1 (HEX_1),
    .o_hex_2 (HEX_2)
  );

endmodule

// File: tb/tb_parking_system.sv
// Directed, table-driven bench for parking_system (honours BLINK_EN).
module tb_parking_system;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] EE = 7'b0000110;
  localparam logic [6:0] NN = 7'b0101011;
  localparam logic [6:0] GG = 7'b0000010;
  localparam logic [6:0] OO = 7'b1000000;
  localparam logic [6:0] SS = 7'b0010010;
  localparam logic [6:0] PP = 7'b0001100;

  // LED expectation codes: steady 0, steady 1, blink phase lit, blink phase dark
  localparam logic [1:0] L0 = 2'd0, L1 = 2'd1, BON = 2'd2, BOFF = 2'd3;

`ifdef BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  typedef struct {
    logic       ent;
    logic       ex;
    logic [1:0] p1;
    logic [1:0] p2;
    logic [6:0] h1;
    logic [6:0] h2;
    logic [1:0] g;
    logic [1:0] r;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sensor_entrance = 1'b0;
  logic       sensor_exit = 1'b0;
  logic [1:0] password_1 = 2'b00;
  logic [1:0] password_2 = 2'b00;
  logic       GREEN_LED;
  logic       RED_LED;
  logic [6:0] HEX_1;
  logic [6:0] HEX_2;

  int total = 0;
  int bad = 0;
  vec_t vecs[$];

  parking_system dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sensor_entrance (sensor_entrance),
    .sensor_exit     (sensor_exit),
    .password_1      (password_1),
    .password_2      (password_2),
    .GREEN_LED       (GREEN_LED),
    .RED_LED         (RED_LED),
    .HEX_1           (HEX_1),
    .HEX_2           (HEX_2)
  );

  always #5 clk = ~clk;

  function automatic logic led(input logic [1:0] code);
    case (code)
      L0:      return 1'b0;
      L1:      return 1'b1;
      BON:     return 1'b1;
      default: return BLINK ? 1'b0 : 1'b1;
    endcase
  endfunction

  function automatic vec_t mk(input logic ent, ex, input logic [1:0] p1, p2,
                              input logic [6:0] h1, h2, input logic [1:0] g, r);
    vec_t v;
    v.ent = ent; v.ex = ex; v.p1 = p1; v.p2 = p2;
    v.h1 = h1; v.h2 = h2; v.g = g; v.r = r;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [6:0] h1, h2, input logic [1:0] g, r);
    chk({nm, " hex1"}, HEX_1, h1);
    chk({nm, " hex2"}, HEX_2, h2);
    chk({nm, " green"}, {6'b0, GREEN_LED}, {6'b0, led(g)});
    chk({nm, " red"}, {6'b0, RED_LED}, {6'b0, led(r)});
  endtask

  task automatic step(input logic ent, ex, input logic [1:0] p1, p2);
    @(negedge clk);
    sensor_entrance = ent;
    sensor_exit     = ex;
    password_1      = p1;
    password_2      = p2;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Correct password, then exit
    vecs.push_back(mk(1'b1, 1'b0, 2'b01, 2'b10, BL, BL, L0, L0));
    vecs.push_back(mk(1'b0, 1'b0, 2'b01, 2'b10, EE, NN, L0, L1));
    vecs.push_back(mk(1'b0, 1'b0, 2'b01, 2'b10, EE, NN, L0, L1));
    vecs.push_back(mk(1'b0, 1'b0, 2'b01, 2'b10, EE, NN, L0, L1));
    vecs.push_back(mk(1'b0, 1'b0, 2'b01, 2'b10, EE, NN, L0, L1));
    vecs.push_back(mk(1'b0, 1'b0, 2'b01, 2'b10, GG, OO, BON, L0));
    vecs.push_back(mk(1'b0, 1'b0, 2'b01, 2'b10, GG, OO, BOFF, L0));
    vecs.push_back(mk(1'b0, 1'b1, 2'b01, 2'b10, GG, OO, BON, L0));
    vecs.push_back(mk(1'b0, 1'b0, 2'b01, 2'b10, BL, BL, L0, L0));
    // Wrong password, correction, tailgate, correction, exit
    vecs.push_back(mk(1'b1, 1'b0, 2'b00, 2'b00, BL, BL, L0, L0));
    vecs.push_back(mk(1'b0, 1'b0, 2'b00, 2'b00, EE, NN, L0, L1));
    vecs.push_back(mk(1'b0, 1'b0, 2'b00, 2'b00, EE, NN, L0, L1));
    vecs.push_back(mk(1'b0, 1'b0, 2'b00, 2'b00, EE, NN, L0, L1));
    vecs.push_back(mk(1'b0, 1'b0, 2'b00, 2'b00, EE, NN, L0, L1));
    vecs.push_back(mk(1'b0, 1'b0, 2'b00, 2'b00, EE, EE, L0, BON));
    vecs.push_back(mk(1'b0, 1'b0, 2'b00, 2'b00, EE, EE, L0, BOFF));
    vecs.push_back(mk(1'b0, 1'b0, 2'b01, 2'b10, EE, EE, L0, BON));
    vecs.push_back(mk(1'b0, 1'b0, 2'b01, 2'b10, GG, OO, BOFF, L0));
    vecs.push_back(mk(1'b1, 1'b1, 2'b00, 2'b00, GG, OO, BON, L0));
    vecs.push_back(mk(1'b0, 1'b0, 2'b00, 2'b00, SS, PP, L0, BOFF));
    vecs.push_back(mk(1'b0, 1'b0, 2'b00, 2'b00, SS, PP, L0, BON));
    vecs.push_back(mk(1'b0, 1'b0, 2'b01, 2'b10, SS, PP, L0, BOFF));
    vecs.push_back(mk(1'b0, 1'b0, 2'b01, 2'b10, GG, OO, BON, L0));
    vecs.push_back(mk(1'b0, 1'b1, 2'b01, 2'b10, GG, OO, BOFF, L0));
    vecs.push_back(mk(1'b0, 1'b0, 2'b01, 2'b10, BL, BL, L0, L0));

    // Reset without a clock edge
    #2 reset_n = 1'b1;
    #1 chk_out("por", BL, BL, L0, L0);
    repeat (2) @(posedge clk);
    #1 chk_out("por held", BL, BL, L0, L0);
    @(negedge clk) reset_n = 1'b0;

    // Vector table, one edge per record
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].ent, vecs[i].ex, vecs[i].p1, vecs[i].p2);
      chk_out($sformatf("vec%0d", i), vecs[i].h1, vecs[i].h2, vecs[i].g, vecs[i].r);
    end

    // Entrance and exit together in IDLE: entrance wins
    step(1'b1, 1'b1, 2'b00, 2'b00);
    step(1'b0, 1'b0, 2'b00, 2'b00);
    chk_out("ent+exit idle", EE, NN, L0, L1);
    repeat (4) step(1'b0, 1'b0, 2'b00, 2'b00);
    chk_out("reach wrong", EE, EE, L0, BON);

    // Asynchronous reset while in WRONG_PASS
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk_out("async rst", BL, BL, L0, L0);
    @(negedge clk) reset_n = 1'b0;
    repeat (3) step(1'b0, 1'b0, 2'b00, 2'b00);
    chk_out("idle after rst", BL, BL, L0, L0);
    step(1'b1, 1'b0, 2'b00, 2'b00);
    step(1'b0, 1'b0, 2'b00, 2'b00);
    chk_out("reentry", EE, NN, L0, L1);

    // Back to IDLE, then watch GREEN over ten RIGHT_PASS cycles
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk) reset_n = 1'b0;
    step(1'b1, 1'b0, 2'b01, 2'b10);
    repeat (4) step(1'b0, 1'b0, 2'b01, 2'b10);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 2'b01, 2'b10);
      chk_out($sformatf("go cyc%0d", k), GG, OO, (k % 2 == 0) ? BON : BOFF, L0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
